// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, default baud/width constants, idle line level.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the receive path imports the same package.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_CLKS_PER_BAUD = 15259;
    localparam int   UART_DATA_BITS     = 8;
    localparam logic UART_IDLE_LVL      = 1'b1;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Per-frame baud divider: counts 0..CLKS_PER_BAUD-1 and pulses tick at terminal count.
// Latency: tick is a decode of the count register, so a bit lasts exactly CLKS_PER_BAUD cycles.
// Backpressure: none; clr holds the count at 0 so each frame starts on a clean bit boundary.
module uart_tx_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = UART_CLKS_PER_BAUD
) (
    input  logic ref_clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W = $clog2(CLKS_PER_BAUD);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BAUD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// UART transmit framer: start, LSB-first data, optional even parity (UART_TX_PARITY_EN), stop bit(s).
// Latency: tx falls on the handshake edge itself; the frame then lasts (1+DATA_BITS+P+STOP_BITS) bit periods.
// Backpressure: tx_ready is high only in IDLE; bytes offered while busy are ignored, no queueing.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = UART_CLKS_PER_BAUD,
    parameter int DATA_BITS     = UART_DATA_BITS,
    parameter int STOP_BITS     = 1
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int               IDX_W     = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    uart_tx_state_t       state;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 baud_clr;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    // Divider sits at zero while idle, so the start bit is a full period from the handshake edge.
    assign baud_clr = (state == ST_IDLE);

    uart_tx_baud_cnt #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_baud_cnt (
        .ref_clk(ref_clk),
        .reset  (reset),
        .clr    (baud_clr),
        .tick   (tick)
    );

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            tx       <= UART_IDLE_LVL;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift    <= tx_data;
                        bit_idx  <= '0;
                        tx       <= ~UART_IDLE_LVL;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= ST_START;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^tx_data;
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx    <= shift[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_DATA) begin
                            // bit_idx is reused to count stop bits.
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= parity;
                            state   <= ST_PARITY;
`else
                            tx      <= UART_IDLE_LVL;
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        tx    <= UART_IDLE_LVL;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx  <= '0;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    tx       <= UART_IDLE_LVL;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    bit_idx  <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
